// File: rtl/tap_edge_monitor.sv
// Timestamps the edges of five delay-line taps relative to the trigger edge and flags ordering and timeout faults.
// Optional: define TAP_MONITOR_ORDER_CHECK_EN to enable the tap-ordering check (err_order is tied low otherwise).
module tap_edge_monitor #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             edge_pol,
  input  logic             trig_in,
  input  logic [4:0]       tap_in,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic [4:0]       seen,
  output logic             err_order,
  output logic             err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_TRIG, S_MEASURE, S_DONE} state_t;

  localparam logic [4:0]       ALL_TAPS    = 5'b11111;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state, state_nxt;
  logic [5:0]       sync1, sync2, hist, edges;
  logic             pol;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] ts [5];
  logic             arm_ok, start, timeout_hit;
  logic [4:0]       cap;

  // Bit 5 carries the trigger so it sees exactly the same latency as the taps.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= {trig_in, tap_in};
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign edges = pol ? (sync2 & ~hist) : (~sync2 & hist);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    arm_ok      = 1'b0;
    start       = 1'b0;
    timeout_hit = 1'b0;
    cap         = '0;
    case (state)
      S_IDLE, S_DONE: begin
        if (arm) begin
          arm_ok    = 1'b1;
          state_nxt = S_WAIT_TRIG;
        end
      end
      S_WAIT_TRIG: begin
        if (edges[5]) begin
          start     = 1'b1;
          cap       = edges[4:0];
          state_nxt = (cap == ALL_TAPS) ? S_DONE : S_MEASURE;
        end
      end
      S_MEASURE: begin
        cap = edges[4:0] & ~seen;
        if ((seen | cap) == ALL_TAPS) begin
          state_nxt = S_DONE;
        end else if (count == TIMEOUT_CNT) begin
          timeout_hit = 1'b1;
          state_nxt   = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Taps captured in the trigger cycle get timestamp 0; the counter reads 1 the cycle after.
  always_ff @(posedge clk) begin
    if (reset) begin
      pol         <= 1'b1;
      count       <= '0;
      seen        <= '0;
      err_timeout <= 1'b0;
      for (int i = 0; i < 5; i++) ts[i] <= '0;
    end else if (arm_ok) begin
      pol         <= edge_pol;
      count       <= '0;
      seen        <= '0;
      err_timeout <= 1'b0;
      for (int i = 0; i < 5; i++) ts[i] <= '0;
    end else begin
      if (start)
        count <= CNT_W'(1);
      else if (state == S_MEASURE && count != CNT_MAX)
        count <= count + CNT_W'(1);
      for (int i = 0; i < 5; i++)
        if (cap[i]) ts[i] <= start ? '0 : count;
      seen <= seen | cap;
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end

`ifdef TAP_MONITOR_ORDER_CHECK_EN
  logic [4:0] covered;
  logic       order_hit;

  // A tap is out of order if any shorter tap is still missing after this cycle's captures.
  always_comb begin
    covered   = seen | cap;
    order_hit = 1'b0;
    for (int i = 1; i < 5; i++)
      for (int j = 0; j < i; j++)
        if (cap[i] && !covered[j]) order_hit = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)          err_order <= 1'b0;
    else if (arm_ok)    err_order <= 1'b0;
    else if (order_hit) err_order <= 1'b1;
  end
`else
  assign err_order = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (rd_sel)
      3'd0:    rd_data = ts[0];
      3'd1:    rd_data = ts[1];
      3'd2:    rd_data = ts[2];
      3'd3:    rd_data = ts[3];
      3'd4:    rd_data = ts[4];
      default: rd_data = '0;
    endcase
  end

  assign busy = (state == S_WAIT_TRIG) || (state == S_MEASURE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_tap_edge_monitor.sv
// Self-checking bench for tap_edge_monitor: directed runs plus randomized runs against an offset-based reference model.
// Honours TAP_MONITOR_ORDER_CHECK_EN for the expected err_order value.
module tb_tap_edge_monitor;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 200;

  logic             clk = 1'b0;
  logic             reset, arm, edge_pol, trig_in;
  logic [4:0]       tap_in;
  logic [2:0]       rd_sel;
  logic [CNT_W-1:0] rd_data;
  logic             busy, done, err_order, err_timeout;
  logic [4:0]       seen;

  int checks   = 0;
  int failures = 0;

  // Offsets in cycles from the trigger toggle; -1 means the line never toggles.
  int cur_off[5];
  bit cur_bounce[5];
  bit trig_bounce;

  tap_edge_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .arm(arm), .edge_pol(edge_pol),
    .trig_in(trig_in), .tap_in(tap_in), .rd_sel(rd_sel),
    .rd_data(rd_data), .busy(busy), .done(done), .seen(seen),
    .err_order(err_order), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level at cycle c: active edge at off, optional return at off+2 and second active edge at off+4.
  function automatic logic lvl(input logic idle, input int off, input bit bnc, input int c);
    logic v;
    v = idle;
    if (off >= 0) begin
      if (c >= off) v = ~v;
      if (bnc && c >= off + 2) v = ~v;
      if (bnc && c >= off + 4) v = ~v;
    end
    return v;
  endfunction

  task automatic setRun(input int o0, input int o1, input int o2, input int o3, input int o4,
                        input bit bnc, input bit tbnc);
    cur_off[0] = o0; cur_off[1] = o1; cur_off[2] = o2; cur_off[3] = o3; cur_off[4] = o4;
    for (int i = 0; i < 5; i++) cur_bounce[i] = bnc;
    trig_bounce = tbnc;
  endtask

  task automatic applyStimulus(input logic pol, input int reset_at, input bit arm_pulses);
    logic idle;
    bit   got_done;
    idle     = ~pol;
    got_done = 0;
    @(posedge clk); #1;
    trig_in = idle;
    tap_in  = {5{idle}};
    repeat (6) @(posedge clk);
    #1 arm = 1'b1; edge_pol = pol;
    @(posedge clk);
    #1 arm = 1'b0; edge_pol = ~pol;
    @(negedge clk);
    check("busy_after_arm", busy, 1'b1);
    check("done_after_arm", done, 1'b0);
    repeat (2) @(posedge clk);
    for (int c = 0; c <= TIMEOUT + 10; c++) begin
      @(posedge clk); #1;
      if (c == reset_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        break;
      end
      arm     = arm_pulses && (c == 1 || c == 6);
      trig_in = lvl(idle, 0, trig_bounce, c);
      for (int i = 0; i < 5; i++) tap_in[i] = lvl(idle, cur_off[i], cur_bounce[i], c);
      @(negedge clk);
      if (done) begin
        got_done = 1;
        arm      = 1'b0;
        break;
      end
    end
    arm = 1'b0;
    if (reset_at < 0) check("done_reached", got_done, 1'b1);
  endtask

  task automatic checkOutput(input string tag);
    logic [CNT_W-1:0] exp_ts[5];
    logic [4:0]       exp_seen;
    logic             exp_order, exp_to;
    bit               all;
    all       = 1;
    exp_order = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_seen[i] = (cur_off[i] >= 0) && (cur_off[i] <= TIMEOUT);
      exp_ts[i]   = exp_seen[i] ? CNT_W'(cur_off[i]) : '0;
      if (!exp_seen[i]) all = 0;
    end
    for (int i = 1; i < 5; i++)
      for (int j = 0; j < i; j++)
        if (exp_seen[i] && (!exp_seen[j] || cur_off[j] > cur_off[i])) exp_order = 1'b1;
`ifndef TAP_MONITOR_ORDER_CHECK_EN
    exp_order = 1'b0;
`endif
    exp_to = !all;
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_seen"}, seen, exp_seen);
    check({tag, "_err_order"}, err_order, exp_order);
    check({tag, "_err_timeout"}, err_timeout, exp_to);
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      rd_sel = 3'(s);
      #1 check($sformatf("%s_ts%0d", tag, s), rd_data, (s < 5) ? exp_ts[s] : '0);
    end
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_seen"}, seen, 5'b0);
    check({tag, "_err_order"}, err_order, 1'b0);
    check({tag, "_err_timeout"}, err_timeout, 1'b0);
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      rd_sel = 3'(s);
      #1 check($sformatf("%s_ts%0d", tag, s), rd_data, '0);
    end
  endtask

  initial begin
    logic rpol;
    reset = 1'b1; arm = 1'b0; edge_pol = 1'b1; trig_in = 1'b0; tap_in = '0; rd_sel = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkReset("reset");

    setRun(5, 10, 15, 20, 25, 0, 0);
    applyStimulus(1'b1, -1, 0);
    checkOutput("basic");

    setRun(5, 10, 15, 20, 20, 0, 0);
    applyStimulus(1'b1, -1, 0);
    checkOutput("same_cycle");

    setRun(4, 12, 8, 16, 20, 0, 0);
    applyStimulus(1'b1, -1, 0);
    checkOutput("order");

    setRun(5, 10, 15, 20, -1, 0, 0);
    applyStimulus(1'b1, -1, 0);
    checkOutput("timeout");

    setRun(0, 3, 7, 11, TIMEOUT, 0, 0);
    applyStimulus(1'b1, -1, 0);
    checkOutput("edge_at_timeout");

    setRun(2, 4, 6, 8, 10, 1, 1);
    applyStimulus(1'b0, -1, 0);
    checkOutput("falling");

    setRun(5, 10, 15, 20, 25, 0, 0);
    applyStimulus(1'b1, 12, 0);
    checkReset("mid_reset");
    repeat (3) @(negedge clk);
    check("idle_after_reset", busy, 1'b0);

    setRun(5, 10, 15, 20, 25, 0, 0);
    applyStimulus(1'b1, -1, 1);
    checkOutput("arm_while_busy");

    for (int r = 0; r < 8; r++) begin
      rpol = 1'($urandom_range(0, 1));
      for (int i = 0; i < 5; i++) begin
        cur_off[i]    = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 40));
        cur_bounce[i] = 1'($urandom_range(0, 1));
      end
      trig_bounce = 1'($urandom_range(0, 1));
      applyStimulus(rpol, -1, 1'($urandom_range(0, 1)));
      checkOutput($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tap_edge_monitor.md
# tap_edge_monitor

Synchronous receiver for the outputs of a five-tap delay line: samples the asynchronous trigger and tap signals, timestamps each tap edge in clock cycles relative to the trigger edge, and flags ordering and timeout faults. Sits on the clocked side of a discrete delay-line part. It lets the timing chain be characterised and checked in simulation and on FPGA boards where the delay line is emulated.

## Interface
Parameters:
- CNT_W, 8, timestamp/counter width in bits
- TIMEOUT, 200, cycles after trigger edge before measurement aborts (must be < 2^CNT_W)

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- arm  input  1  one-cycle request to start a measurement; honoured only in IDLE or DONE
- edge_pol  input  1  edge polarity, latched on accepted arm: 1 = rising, 0 = falling
- trig_in  input  1  asynchronous delay-line input (the signal driving the delay line)
- tap_in  input  5  asynchronous tap outputs, bit 0 = shortest tap, bit 4 = longest
- rd_sel  input  3  timestamp read select, 0..4; 5..7 read as zero
- rd_data  output  CNT_W  captured timestamp of tap rd_sel (combinational mux of capture regs)
- busy  output  1  high in WAIT_TRIG and MEASURE
- done  output  1  high in DONE until next accepted arm
- seen  output  5  per-tap edge-captured flags
- err_order  output  1  sticky: a tap edge arrived before a shorter tap's edge
- err_timeout  output  1  sticky: TIMEOUT reached with taps missing

## Operation
- Input conditioning: trig_in and each tap_in pass through an identical two-flop synchroniser plus one history flop. Edge = sync & ~hist (rising) or ~sync & hist (falling) per latched polarity. Synchronisers run in every state and reset to 0.
- States: IDLE -> (arm) WAIT_TRIG -> (trigger edge) MEASURE -> (all seen or timeout) DONE -> (arm) WAIT_TRIG.
- Accepted arm clears seen, timestamps, err_order, err_timeout and done; latches edge_pol. arm while busy is ignored.
- WAIT_TRIG: tap edges ignored unless coincident with the trigger edge. On trigger edge, counter := 1 next cycle, and any tap edge detected in that same cycle captures timestamp 0.
- MEASURE: counter increments each cycle, saturating at 2^CNT_W-1. A tap edge on an unseen tap captures the current counter value and sets seen[i]. Later edges on a seen tap are ignored.
- Multiple taps in one cycle capture equal values; legal.
- Ordering: capturing tap i while any tap j<i is neither already seen nor captured in the same cycle sets err_order.
- Completion: seen == 5'b11111 -> DONE next cycle. Counter == TIMEOUT with seen incomplete -> err_timeout set, DONE next cycle.
- reset in any state: state IDLE, counter 0, all timestamps 0, all flags 0, edge_pol latch 1.

## Timing
- Reset values: rd_data 0, busy 0, done 0, seen 0, err_order 0, err_timeout 0.
- Input-to-detect latency: 3 clk edges, identical for trigger and taps, so relative timestamps carry no offset. Async quantisation is ±1 cycle.
- Timestamp = number of clk cycles between the trigger-detect cycle and the tap-detect cycle.
- busy rises the cycle after an accepted arm. done rises the cycle after the completing capture or timeout. busy and done are never high together.
- Flags and timestamps are registered and stable throughout DONE. rd_data follows rd_sel combinationally.

## Configuration
- TAP_MONITOR_ORDER_CHECK_EN defined: ordering check active as above.
- Not defined: ordering logic omitted, err_order tied 0, and captures proceed identically.

## Test plan
- Reset, arm rising, trigger and taps driven synchronously: trigger detected, taps detected 5/10/15/20/25 cycles later -> timestamps 5,10,15,20,25; seen=11111; done=1; both errors 0.
- Taps 3 and 4 detected in the same cycle (20) -> both timestamps 20, err_order 0.
- Tap 2 edge at 8, tap 1 at 12 -> err_order=1, timestamps 12/8 for taps 1/2. With the macro undefined -> err_order=0.
- Tap 4 never toggles, TIMEOUT=200 -> DONE at count 200, err_timeout=1, seen=01111, rd_sel=4 reads 0.
- Falling-edge mode with edge_pol=0: first do a rising-edge run, then arm with edge_pol=0 and return lines low at offsets 2,4,6,8,10 -> those timestamps; rising edges ignored.
- reset asserted mid-MEASURE, then arm during a busy phase -> all outputs 0 and IDLE after reset; a second arm while busy is ignored, and timestamps of the original run are kept.
